mant_align_norm: RTL and testbench

- Pipelined significand datapath of the small-float adder (3-bit exponent); sits directly upstream of the exponent-adjust stage.
- Aligns the smaller operand by the exponent difference, adds or subtracts significands, then normalises the result.
- Emits the normalisation amount/direction pair (exp_diff_norm, exp_diff_sign) the exponent stage consumes, with both operand exponents re-timed alongside.
- 3-stage pipeline with valid/ready flow control.

---
 rtl/mant_align_norm.sv | 234 +++++++++++++++++++++++
 tb/tb_mant_align_norm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mant_align_norm.sv
// Significand datapath of the small-float adder: align, add/subtract, normalise.
// Three registered stages with valid/ready flow control; the normalisation amount
// and direction go to the downstream exponent-adjust stage.
module mant_align_norm #(
    parameter int unsigned MW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sign_a,
    input  logic          sign_b,
    input  logic [2:0]    exp_a,
    input  logic [2:0]    exp_b,
    input  logic [MW-1:0] mant_a,
    input  logic [MW-1:0] mant_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_exp_a,
    output logic [2:0]    out_exp_b,
    output logic          sign_res,
    output logic [MW-1:0] mant_res,
    output logic [2:0]    exp_diff_norm,
    output logic [1:0]    exp_diff_sign,
    output logic          zero_res
);

    // EW: significand plus guard bit; SW: EW plus carry bit.
    localparam int unsigned EW = MW + 1;
    localparam int unsigned SW = MW + 2;

    // Stage 1 registers (aligned operands)
    logic          s1_valid_q, s1_valid_d;
    logic          s1_sign_big_q, s1_sign_big_d;
    logic          s1_sign_small_q, s1_sign_small_d;
    logic [EW-1:0] s1_big_q, s1_big_d;
    logic [EW-1:0] s1_small_q, s1_small_d;
    logic [2:0]    s1_exp_a_q, s1_exp_a_d;
    logic [2:0]    s1_exp_b_q, s1_exp_b_d;

    // Stage 2 registers (raw sum/difference magnitude)
    logic          s2_valid_q, s2_valid_d;
    logic          s2_sign_q, s2_sign_d;
    logic [SW-1:0] s2_sum_q, s2_sum_d;
    logic [2:0]    s2_exp_a_q, s2_exp_a_d;
    logic [2:0]    s2_exp_b_q, s2_exp_b_d;

    // Stage 3 registers (normalised result, drive the outputs directly)
    logic          s3_valid_q, s3_valid_d;
    logic          s3_sign_q, s3_sign_d;
    logic [MW-1:0] s3_mant_q, s3_mant_d;
    logic [2:0]    s3_norm_q, s3_norm_d;
    logic [1:0]    s3_dsign_q, s3_dsign_d;
    logic          s3_zero_q, s3_zero_d;
    logic [2:0]    s3_exp_a_q, s3_exp_a_d;
    logic [2:0]    s3_exp_b_q, s3_exp_b_d;

    logic ld1, ld2, ld3;

    // Stage load enables: a stage loads when empty or when its successor takes its content.
    always_comb begin
        ld3      = !s3_valid_q || out_ready;
        ld2      = !s2_valid_q || ld3;
        ld1      = !s1_valid_q || ld2;
        in_ready = ld1;
    end

    logic [3:0]    diff;
    logic [3:0]    shamt;
    logic          b_larger;
    logic [EW-1:0] small_ext;

    // Stage 1: pick the larger-exponent operand and right-align the other by |diff|.
    always_comb begin
        diff            = {1'b0, exp_a} - {1'b0, exp_b};
        b_larger        = diff[3];
        shamt           = b_larger ? (4'd0 - diff) : diff;
        small_ext       = b_larger ? {mant_a, 1'b0} : {mant_b, 1'b0};
        s1_valid_d      = ld1 ? in_valid : s1_valid_q;
        s1_sign_big_d   = s1_sign_big_q;
        s1_sign_small_d = s1_sign_small_q;
        s1_big_d        = s1_big_q;
        s1_small_d      = s1_small_q;
        s1_exp_a_d      = s1_exp_a_q;
        s1_exp_b_d      = s1_exp_b_q;
        if (ld1 && in_valid) begin
            s1_sign_big_d   = b_larger ? sign_b : sign_a;
            s1_sign_small_d = b_larger ? sign_a : sign_b;
            s1_big_d        = b_larger ? {mant_b, 1'b0} : {mant_a, 1'b0};
            s1_small_d      = (shamt >= 4'(EW)) ? '0 : (small_ext >> shamt);
            s1_exp_a_d      = exp_a;
            s1_exp_b_d      = exp_b;
        end
    end

    logic [SW-1:0] raw;

    // Stage 2: add on equal signs, otherwise subtract and fold a negative result back to magnitude.
    always_comb begin
        raw        = {1'b0, s1_big_q} - {1'b0, s1_small_q};
        s2_valid_d = ld2 ? s1_valid_q : s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_sum_d   = s2_sum_q;
        s2_exp_a_d = s2_exp_a_q;
        s2_exp_b_d = s2_exp_b_q;
        if (ld2 && s1_valid_q) begin
            s2_exp_a_d = s1_exp_a_q;
            s2_exp_b_d = s1_exp_b_q;
            if (s1_sign_big_q == s1_sign_small_q) begin
                s2_sum_d  = {1'b0, s1_big_q} + {1'b0, s1_small_q};
                s2_sign_d = s1_sign_big_q;
            end else if (raw[SW-1]) begin
                // Only reachable with equal exponents and SMALL > BIG.
                s2_sum_d  = '0 - raw;
                s2_sign_d = s1_sign_small_q;
            end else begin
                s2_sum_d  = raw;
                s2_sign_d = s1_sign_big_q;
            end
        end
    end

    logic [3:0] lzc;
    logic       found;

    // Stage 3: count leading zeros above the guard bit and normalise (truncating).
    always_comb begin
        lzc   = 4'd0;
        found = 1'b0;
        for (int i = MW; i >= 1; i--) begin
            if (!found) begin
                if (s2_sum_q[i]) begin
                    found = 1'b1;
                end else begin
                    lzc = lzc + 4'd1;
                end
            end
        end
        s3_valid_d = ld3 ? s2_valid_q : s3_valid_q;
        s3_sign_d  = s3_sign_q;
        s3_mant_d  = s3_mant_q;
        s3_norm_d  = s3_norm_q;
        s3_dsign_d = s3_dsign_q;
        s3_zero_d  = s3_zero_q;
        s3_exp_a_d = s3_exp_a_q;
        s3_exp_b_d = s3_exp_b_q;
        if (ld3 && s2_valid_q) begin
            s3_exp_a_d = s2_exp_a_q;
            s3_exp_b_d = s2_exp_b_q;
            s3_zero_d  = 1'b0;
            s3_sign_d  = s2_sign_q;
            if (s2_sum_q == '0) begin
                s3_mant_d  = '0;
                s3_norm_d  = 3'd0;
                s3_dsign_d = 2'b00;
                s3_zero_d  = 1'b1;
                s3_sign_d  = 1'b0;
            end else if (s2_sum_q[SW-1]) begin
                s3_mant_d  = s2_sum_q[SW-1:2];
                s3_norm_d  = 3'd1;
                s3_dsign_d = 2'b01;
            end else if (lzc == 4'd0) begin
                s3_mant_d  = s2_sum_q[MW:1];
                s3_norm_d  = 3'd0;
                s3_dsign_d = 2'b00;
            end else begin
                // Guard bit enters the significand first, zeros follow.
                s3_mant_d  = MW'((s2_sum_q[MW:0] << lzc) >> 1);
                s3_norm_d  = lzc[2:0];
                s3_dsign_d = 2'b11;
            end
        end
    end

    // Pipeline state registers; reset flushes every stage at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q      <= 1'b0;
            s1_sign_big_q   <= 1'b0;
            s1_sign_small_q <= 1'b0;
            s1_big_q        <= '0;
            s1_small_q      <= '0;
            s1_exp_a_q      <= 3'd0;
            s1_exp_b_q      <= 3'd0;
            s2_valid_q      <= 1'b0;
            s2_sign_q       <= 1'b0;
            s2_sum_q        <= '0;
            s2_exp_a_q      <= 3'd0;
            s2_exp_b_q      <= 3'd0;
            s3_valid_q      <= 1'b0;
            s3_sign_q       <= 1'b0;
            s3_mant_q       <= '0;
            s3_norm_q       <= 3'd0;
            s3_dsign_q      <= 2'b00;
            s3_zero_q       <= 1'b0;
            s3_exp_a_q      <= 3'd0;
            s3_exp_b_q      <= 3'd0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_sign_big_q   <= s1_sign_big_d;
            s1_sign_small_q <= s1_sign_small_d;
            s1_big_q        <= s1_big_d;
            s1_small_q      <= s1_small_d;
            s1_exp_a_q      <= s1_exp_a_d;
            s1_exp_b_q      <= s1_exp_b_d;
            s2_valid_q      <= s2_valid_d;
            s2_sign_q       <= s2_sign_d;
            s2_sum_q        <= s2_sum_d;
            s2_exp_a_q      <= s2_exp_a_d;
            s2_exp_b_q      <= s2_exp_b_d;
            s3_valid_q      <= s3_valid_d;
            s3_sign_q       <= s3_sign_d;
            s3_mant_q       <= s3_mant_d;
            s3_norm_q       <= s3_norm_d;
            s3_dsign_q      <= s3_dsign_d;
            s3_zero_q       <= s3_zero_d;
            s3_exp_a_q      <= s3_exp_a_d;
            s3_exp_b_q      <= s3_exp_b_d;
        end
    end

    // Outputs come straight from stage 3 so they hold while stalled.
    always_comb begin
        out_valid     = s3_valid_q;
        out_exp_a     = s3_exp_a_q;
        out_exp_b     = s3_exp_b_q;
        sign_res      = s3_sign_q;
        mant_res      = s3_mant_q;
        exp_diff_norm = s3_norm_q;
        exp_diff_sign = s3_dsign_q;
        zero_res      = s3_zero_q;
    end

endmodule

// File: tb/tb_mant_align_norm.sv
// Directed self-checking bench for mant_align_norm (MW=5).
module tb_mant_align_norm;

    localparam int unsigned MW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          sign_a, sign_b;
    logic [2:0]    exp_a, exp_b;
    logic [MW-1:0] mant_a, mant_b;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_exp_a, out_exp_b;
    logic          sign_res;
    logic [MW-1:0] mant_res;
    logic [2:0]    exp_diff_norm;
    logic [1:0]    exp_diff_sign;
    logic          zero_res;

    int n_checks = 0;
    int n_pass   = 0;

    mant_align_norm #(.MW(MW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sign_a        (sign_a),
        .sign_b        (sign_b),
        .exp_a         (exp_a),
        .exp_b         (exp_b),
        .mant_a        (mant_a),
        .mant_b        (mant_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_exp_a     (out_exp_a),
        .out_exp_b     (out_exp_b),
        .sign_res      (sign_res),
        .mant_res      (mant_res),
        .exp_diff_norm (exp_diff_norm),
        .exp_diff_sign (exp_diff_sign),
        .zero_res      (zero_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic sa, input logic [2:0] ea, input logic [MW-1:0] ma,
                         input logic sb, input logic [2:0] eb, input logic [MW-1:0] mb);
        sign_a = sa; exp_a = ea; mant_a = ma;
        sign_b = sb; exp_b = eb; mant_b = mb;
    endtask

    // Send one operand pair with out_ready=1, measure latency, check every result field.
    task automatic run_vec(input string tag,
                           input logic sa, input logic [2:0] ea, input logic [MW-1:0] ma,
                           input logic sb, input logic [2:0] eb, input logic [MW-1:0] mb,
                           input logic [MW-1:0] e_mant, input logic [2:0] e_norm,
                           input logic [1:0] e_dsign, input logic e_sign, input logic e_zero);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        drive(sa, ea, ma, sb, eb, mb);
        in_valid = 1'b1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ".latency"}, 32'(lat), 32'd3);
        check({tag, ".mant_res"}, 32'(mant_res), 32'(e_mant));
        check({tag, ".norm"}, 32'(exp_diff_norm), 32'(e_norm));
        check({tag, ".dsign"}, 32'(exp_diff_sign), 32'(e_dsign));
        check({tag, ".sign_res"}, 32'(sign_res), 32'(e_sign));
        check({tag, ".zero_res"}, 32'(zero_res), 32'(e_zero));
        check({tag, ".exp_a"}, 32'(out_exp_a), 32'(ea));
        check({tag, ".exp_b"}, 32'(out_exp_b), 32'(eb));
    endtask

    logic [MW-1:0] bp_mant [4];
    int            accepted;
    int            drained;
    int            cyc;

    initial begin
        bp_mant[0] = 5'b10001;
        bp_mant[1] = 5'b10010;
        bp_mant[2] = 5'b10011;
        bp_mant[3] = 5'b10100;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, '0, 1'b0, 3'd0, '0);
        repeat (3) @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.mant_res", 32'(mant_res), 32'd0);
        check("rst.norm", 32'({exp_diff_norm, exp_diff_sign}), 32'd0);
        check("rst.misc", 32'({zero_res, sign_res, out_exp_a, out_exp_b}), 32'd0);
        rst = 1'b0;

        run_vec("carry", 1'b0, 3'd3, 5'b10000, 1'b0, 3'd3, 5'b10000,
                5'b10000, 3'd1, 2'b01, 1'b0, 1'b0);
        run_vec("cancel", 1'b0, 3'd2, 5'b10100, 1'b1, 3'd2, 5'b10100,
                5'b00000, 3'd0, 2'b00, 1'b0, 1'b1);
        run_vec("align_b", 1'b0, 3'd2, 5'b10000, 1'b1, 3'd5, 5'b10000,
                5'b11100, 3'd1, 2'b11, 1'b1, 1'b0);
        run_vec("neg_sub", 1'b0, 3'd4, 5'b10000, 1'b1, 3'd4, 5'b11000,
                5'b10000, 3'd1, 2'b11, 1'b1, 1'b0);
        // 110000>>3 = 000110; 100000+000110 = 100110 -> 10011, no shift
        run_vec("align_a", 1'b0, 3'd5, 5'b10000, 1'b0, 3'd2, 5'b11000,
                5'b10011, 3'd0, 2'b00, 1'b0, 1'b0);
        // shift 7 >= 6 flushes SMALL; result is BIG unchanged
        run_vec("flush", 1'b1, 3'd7, 5'b10001, 1'b0, 3'd0, 5'b11111,
                5'b10001, 3'd0, 2'b00, 1'b1, 1'b0);
        // 111010>>1 = 011101; 100000-011101 = 000011 -> lzc 4, guard enters -> 11000
        run_vec("guard", 1'b0, 3'd1, 5'b10000, 1'b1, 3'd0, 5'b11101,
                5'b11000, 3'd4, 2'b11, 1'b0, 1'b0);

        // Backpressure: offer 4 items with out_ready low for 6 cycles.
        accepted = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (accepted < 4) begin
                drive(1'b0, 3'd3, bp_mant[accepted], 1'b0, 3'd3, 5'b00000);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            cyc = (in_valid && in_ready) ? 1 : 0;
            @(posedge clk);
            accepted += cyc;
            @(negedge clk);
        end
        check("bp.accepted", 32'(accepted), 32'd3);
        check("bp.in_ready", 32'(in_ready), 32'd0);
        check("bp.hold_valid", 32'(out_valid), 32'd1);
        check("bp.hold_mant", 32'(mant_res), 32'(bp_mant[0]));
        out_ready = 1'b1;
        drained = 0;
        cyc = 0;
        while (drained < 4 && cyc < 40) begin
            if (out_valid) begin
                check($sformatf("bp.order%0d", drained), 32'(mant_res), 32'(bp_mant[drained]));
                drained++;
            end
            if (accepted < 4) begin
                drive(1'b0, 3'd3, bp_mant[accepted], 1'b0, 3'd3, 5'b00000);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) accepted++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("bp.drained", 32'(drained), 32'd4);

        // Reset with two items in flight.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b0, 3'd3, 5'b10000, 1'b0, 3'd3, 5'b10000);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 3'd5, 5'b10000, 1'b0, 3'd2, 5'b11000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("mid.pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.out_valid", 32'(out_valid), 32'd0);
        check("mid.mant_res", 32'(mant_res), 32'd0);
        check("mid.norm", 32'({exp_diff_norm, exp_diff_sign, out_exp_a}), 32'd0);
        check("mid.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("mid.no_stale", 32'(out_valid), 32'd0);
        run_vec("post_rst", 1'b0, 3'd2, 5'b10000, 1'b1, 3'd5, 5'b10000,
                5'b11100, 3'd1, 2'b11, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
